// File: rtl/ahb_mtx_in_stg_pkg.sv
// rtl/ahb_mtx_in_stg_pkg.sv - shared AHB encodings and field widths for the matrix input stage
package ahb_mtx_in_stg_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int SIZE_W  = 3;
  localparam int BURST_W = 3;
  localparam int PROT_W  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } hold_st_t;

endpackage

// File: rtl/ahb_mtx_in_stg.sv
// rtl/ahb_mtx_in_stg.sv - bus-matrix input stage: holds a refused address phase and relays data-phase status
module ahb_mtx_in_stg
  import ahb_mtx_in_stg_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSELS,
  input  logic [ADDR_W-1:0]   HADDRS,
  input  logic [1:0]          HTRANSS,
  input  logic                HWRITES,
  input  logic [SIZE_W-1:0]   HSIZES,
  input  logic [BURST_W-1:0]  HBURSTS,
  input  logic [PROT_W-1:0]   HPROTS,
  input  logic                HMASTLOCKS,
  input  logic                HREADYS,
  output logic                HREADYOUTS,
  output logic                HRESPS,
  output logic                trans_pend,
  input  logic                active,
  input  logic                HREADYM,
  input  logic                HRESPM,
  output logic [ADDR_W-1:0]   HADDRM,
  output logic [1:0]          HTRANSM,
  output logic                HWRITEM,
  output logic [SIZE_W-1:0]   HSIZEM,
  output logic [BURST_W-1:0]  HBURSTM,
  output logic [PROT_W-1:0]   HPROTM,
  output logic                HMASTLOCKM
);

  hold_st_t state_q, state_d;
  logic     pend_reg;
  logic     dphase_reg;
  logic     new_tran;
  logic     accept;
  logic     err_first;

  logic [ADDR_W-1:0]  addr_q;
  logic [1:0]         trans_q;
  logic               write_q;
  logic [SIZE_W-1:0]  size_q;
  logic [BURST_W-1:0] burst_q;
  logic [PROT_W-1:0]  prot_q;
  logic               lock_q;

  assign pend_reg   = (state_q == ST_HOLD);
  assign new_tran   = HSELS & HTRANSS[1] & HREADYS;
  assign trans_pend = pend_reg | new_tran;
  assign accept     = trans_pend & active & HREADYM;
  assign err_first  = dphase_reg & (HRESPM == HRESP_ERROR) & ~HREADYM;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // An ERROR on the previous transfer cancels the held one: the master may go IDLE next.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (new_tran && !accept)      state_d = ST_HOLD;
      ST_HOLD: if (accept || err_first)      state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dphase_reg <= 1'b0;
    end else if (HREADYM || !dphase_reg) begin
      dphase_reg <= accept & HTRANSM[1];
    end
  end

  // Held address/control bank; frozen while a refused transfer is waiting for grant.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q  <= '0;
      trans_q <= HTRANS_IDLE;
      write_q <= 1'b0;
      size_q  <= '0;
      burst_q <= '0;
      prot_q  <= '0;
      lock_q  <= 1'b0;
    end else if (HREADYS && HSELS && !pend_reg) begin
      addr_q  <= HADDRS;
      trans_q <= HTRANSS;
      write_q <= HWRITES;
      size_q  <= HSIZES;
      burst_q <= HBURSTS;
      prot_q  <= HPROTS;
      lock_q  <= HMASTLOCKS;
    end
  end

  always_comb begin
    if (pend_reg) begin
      HADDRM     = addr_q;
      HTRANSM    = trans_q;
      HWRITEM    = write_q;
      HSIZEM     = size_q;
      HBURSTM    = burst_q;
      HPROTM     = prot_q;
      HMASTLOCKM = lock_q;
    end else begin
      HADDRM     = HADDRS;
      HTRANSM    = HSELS ? HTRANSS : HTRANS_IDLE;
      HWRITEM    = HWRITES;
      HSIZEM     = HSIZES;
      HBURSTM    = HBURSTS;
      HPROTM     = HPROTS;
      HMASTLOCKM = HMASTLOCKS;
    end
  end

  always_comb begin
    if (dphase_reg)    HREADYOUTS = HREADYM;
    else if (pend_reg) HREADYOUTS = 1'b0;
    else               HREADYOUTS = 1'b1;
  end

  assign HRESPS = dphase_reg ? HRESPM : HRESP_OKAY;

endmodule
